viterbi_acs_ctrl: RTL and testbench

Frame-level sequencer for the K=3, rate-1/2 Viterbi decoder. It owns the four state-metric registers that feed the ACS unit and gates symbol acceptance with a valid/ready handshake. Each accepted symbol it captures the ACS results, renormalizes them, and writes the four decision bits to survivor memory. At end of frame it hands traceback the best end state and waits for traceback to finish.

---
 rtl/viterbi_pkg.sv | 21 ++
 rtl/viterbi_min4.sv | 43 ++++
 rtl/viterbi_acs_ctrl.sv | 143 ++++++++++++++
 tb/tb_viterbi_acs_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 Viterbi decoder control path:
// default widths, trellis state indices and the frame sequencer state enum.
package viterbi_pkg;

  localparam int MW_DEF     = 4;
  localparam int ADDR_W_DEF = 6;

  localparam logic [1:0] S00 = 2'd0;
  localparam logic [1:0] S01 = 2'd1;
  localparam logic [1:0] S10 = 2'd2;
  localparam logic [1:0] S11 = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    TB_ISSUE = 3'd2,
    TB_WAIT  = 3'd3,
    DONE     = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/viterbi_min4.sv
// Combinational minimum of four metrics with its 2-bit state index.
// Ties resolve to the lowest index (00 < 01 < 10 < 11).
module viterbi_min4
  import viterbi_pkg::*;
#(
  parameter int W = MW_DEF
) (
  input  logic [W-1:0] m0,
  input  logic [W-1:0] m1,
  input  logic [W-1:0] m2,
  input  logic [W-1:0] m3,
  output logic [W-1:0] min_val,
  output logic [1:0]   min_idx
);

  logic [W-1:0] lo_a;
  logic [W-1:0] lo_b;
  logic [1:0]   idx_a;
  logic [1:0]   idx_b;

  // Strict less-than everywhere so an equal value never displaces a lower index.
  always_comb begin
    lo_a  = m0;
    idx_a = S00;
    lo_b  = m2;
    idx_b = S10;
    if (m1 < m0) begin
      lo_a  = m1;
      idx_a = S01;
    end
    if (m3 < m2) begin
      lo_b  = m3;
      idx_b = S11;
    end
    min_val = lo_a;
    min_idx = idx_a;
    if (lo_b < lo_a) begin
      min_val = lo_b;
      min_idx = idx_b;
    end
  end

endmodule

// File: rtl/viterbi_acs_ctrl.sv
// Frame sequencer for the Viterbi decoder: owns the state metrics, accepts
// symbols, writes survivor decisions, then launches and waits on traceback.
module viterbi_acs_ctrl
  import viterbi_pkg::*;
#(
  parameter int MW        = MW_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int INIT_BIAS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [MW-1:0]     acs00_cost,
  input  logic [MW-1:0]     acs01_cost,
  input  logic [MW-1:0]     acs10_cost,
  input  logic [MW-1:0]     acs11_cost,
  input  logic [3:0]        acs_sel,
  output logic [MW-1:0]     pm00,
  output logic [MW-1:0]     pm01,
  output logic [MW-1:0]     pm10,
  output logic [MW-1:0]     pm11,
  output logic              surv_we,
  output logic [ADDR_W-1:0] surv_addr,
  output logic [3:0]        surv_data,
  output logic              tb_start,
  output logic [1:0]        tb_state,
  output logic [ADDR_W:0]   tb_len,
  input  logic              tb_done,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  localparam logic [MW-1:0]   BIAS    = MW'(INIT_BIAS);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  ctrl_state_e     state;
  ctrl_state_e     state_nxt;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] len;
  logic [MW-1:0]   acs_min;
  logic [1:0]      acs_min_idx;
  logic [MW-1:0]   pm_min;
  logic [1:0]      best_idx;
  logic            start_ok;
  logic            accept;
  logic            last_sym;
  logic            unused_min_side;

  viterbi_min4 #(.W(MW)) u_acs_min (
    .m0(acs00_cost), .m1(acs01_cost), .m2(acs10_cost), .m3(acs11_cost),
    .min_val(acs_min), .min_idx(acs_min_idx)
  );

  viterbi_min4 #(.W(MW)) u_best (
    .m0(pm00), .m1(pm01), .m2(pm10), .m3(pm11),
    .min_val(pm_min), .min_idx(best_idx)
  );

  assign unused_min_side = ^{acs_min_idx, pm_min};

  // Handshake: a symbol transfers in any cycle where sym_valid && sym_ready.
  // sym_ready depends only on state; the ACS costs and acs_sel must be stable
  // with sym_valid and are consumed in that same cycle.
  assign start_ok  = start && (frame_len != '0);
  assign accept    = (state == RUN) && sym_valid;
  assign last_sym  = (cnt == (len - CNT_ONE));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sym_ready  = 1'b0;
    surv_we    = 1'b0;
    surv_addr  = '0;
    surv_data  = '0;
    tb_start   = 1'b0;
    tb_state   = S00;
    tb_len     = '0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = RUN;
      end
      RUN: begin
        sym_ready = 1'b1;
        surv_we   = sym_valid;
        surv_addr = cnt[ADDR_W-1:0];
        surv_data = acs_sel;
        if (sym_valid && last_sym) state_nxt = TB_ISSUE;
      end
      TB_ISSUE: begin
        tb_start  = 1'b1;
        tb_state  = best_idx;
        tb_len    = len;
        state_nxt = TB_WAIT;
      end
      TB_WAIT: begin
        if (tb_done) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Renormalize against the smallest new cost so metrics stay small and unsigned.
  always_ff @(posedge clk) begin
    if (rst) begin
      pm00 <= '0;
      pm01 <= '0;
      pm10 <= '0;
      pm11 <= '0;
      cnt  <= '0;
      len  <= '0;
    end else if (state == IDLE && start_ok) begin
      pm00 <= '0;
      pm01 <= BIAS;
      pm10 <= BIAS;
      pm11 <= BIAS;
      cnt  <= '0;
      len  <= frame_len;
    end else if (accept) begin
      pm00 <= acs00_cost - acs_min;
      pm01 <= acs01_cost - acs_min;
      pm10 <= acs10_cost - acs_min;
      pm11 <= acs11_cost - acs_min;
      cnt  <= cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Self-checking bench for viterbi_acs_ctrl: table vectors for renormalization
// and best-state choice, hand sequences for corner cases, randomized frames.
module tb_viterbi_acs_ctrl;

  localparam int AW   = 6;
  localparam int MWT  = 4;
  localparam int BIAS = 4;

  logic           clk, rst, start, sym_valid, sym_ready;
  logic [AW:0]    frame_len;
  logic [MWT-1:0] acs00_cost, acs01_cost, acs10_cost, acs11_cost;
  logic [3:0]     acs_sel;
  logic [MWT-1:0] pm00, pm01, pm10, pm11;
  logic           surv_we, tb_start, tb_done, busy, frame_done;
  logic [AW-1:0]  surv_addr;
  logic [3:0]     surv_data;
  logic [1:0]     tb_state;
  logic [AW:0]    tb_len;
  logic [2:0]     dbg_state;

  viterbi_acs_ctrl #(.MW(MWT), .ADDR_W(AW), .INIT_BIAS(BIAS)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .acs00_cost(acs00_cost), .acs01_cost(acs01_cost),
    .acs10_cost(acs10_cost), .acs11_cost(acs11_cost), .acs_sel(acs_sel),
    .pm00(pm00), .pm01(pm01), .pm10(pm10), .pm11(pm11),
    .surv_we(surv_we), .surv_addr(surv_addr), .surv_data(surv_data),
    .tb_start(tb_start), .tb_state(tb_state), .tb_len(tb_len),
    .tb_done(tb_done), .busy(busy), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [AW+3:0] exp_q[$];
  int m[4];  // reference path metrics

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_pm(input string tag);
    chk({tag, "_pm00"}, pm00, m[0]);
    chk({tag, "_pm01"}, pm01, m[1]);
    chk({tag, "_pm10"}, pm10, m[2]);
    chk({tag, "_pm11"}, pm11, m[3]);
  endtask

  function automatic int best_state();
    int b = 0;
    for (int i = 1; i < 4; i++) if (m[i] < m[b]) b = i;
    return b;
  endfunction

  task automatic check_write(input bit expect_we);
    logic [AW+3:0] e;
    chk("surv_we", surv_we, expect_we);
    if (surv_we) begin
      if (exp_q.size() == 0) chk("surv_unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("surv_addr_data", {surv_addr, surv_data}, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic run_frame(input int len, input bit rand_costs, input bit use_mask,
                           input logic [31:0] vmask, input bit strays);
    int acc = 0;
    int cyc = 0;
    int mn;
    bit v;
    logic [3:0] cv[4];
    start = 1'b1; frame_len = (AW+1)'(len); sym_valid = 1'b0;
    settle();
    chk("idle_ready", sym_ready, 0);
    tick();
    start = 1'b0;
    m = '{0, BIAS, BIAS, BIAS};
    while (acc < len && cyc < 400) begin
      v = use_mask ? vmask[cyc % 32] : ($urandom_range(0, 3) != 0);
      if (rand_costs) for (int i = 0; i < 4; i++) cv[i] = 4'($urandom_range(0, 15));
      else cv = '{4'd5, 4'd7, 4'd6, 4'd9};
      {acs00_cost, acs01_cost, acs10_cost, acs11_cost} = {cv[0], cv[1], cv[2], cv[3]};
      acs_sel   = 4'($urandom);
      sym_valid = v;
      tb_done   = strays && ($urandom_range(0, 2) == 0);
      start     = strays && ($urandom_range(0, 2) == 0);
      frame_len = (AW+1)'($urandom_range(1, 64));
      if (v) exp_q.push_back({acc[AW-1:0], acs_sel});
      settle();
      chk("run_ready", sym_ready, 1);
      chk("run_busy", busy, 1);
      chk_pm("run");
      check_write(v);
      if (v) begin
        mn = cv[0];
        for (int i = 1; i < 4; i++) if (cv[i] < mn) mn = cv[i];
        for (int i = 0; i < 4; i++) m[i] = cv[i] - mn;
        acc++;
      end
      cyc++;
      tick();
    end
    if (acc < len) chk("run_timeout", 1, 0);
    sym_valid = 1'b0; start = 1'b0; tb_done = strays;
    settle();
    chk("tb_start", tb_start, 1);
    chk("tb_state", tb_state, best_state());
    chk("tb_len", tb_len, len);
    chk("issue_ready", sym_ready, 0);
    chk("issue_we", surv_we, 0);
    chk_pm("issue");
    tick();
    tb_done = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      start = strays; frame_len = (AW+1)'($urandom_range(1, 64)); sym_valid = strays;
      settle();
      chk("wait_busy", busy, 1);
      chk("wait_tb_start", tb_start, 0);
      chk("wait_frame_done", frame_done, 0);
      chk("wait_ready", sym_ready, 0);
      chk("wait_we", surv_we, 0);
      chk_pm("wait");
      tick();
    end
    start = 1'b0; sym_valid = 1'b0; tb_done = 1'b1;
    settle();
    chk("done_not_early", frame_done, 0);
    tick();
    tb_done = 1'b0; start = strays; frame_len = 7'd3;
    settle();
    chk("frame_done", frame_done, 1);
    chk("done_busy", busy, 1);
    tick();
    start = 1'b0;
    settle();
    chk("back_idle_busy", busy, 0);
    chk("back_idle_frame_done", frame_done, 0);
    tick();
  endtask

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic [3:0] c0, c1, c2, c3, sel, p0, p1, p2, p3;
    logic [1:0] best;
  } vec_t;

  vec_t vecs[7];

  initial begin
    rst = 1'b1; start = 1'b0; frame_len = '0; sym_valid = 1'b0; tb_done = 1'b0;
    {acs00_cost, acs01_cost, acs10_cost, acs11_cost, acs_sel} = '0;
    m = '{0, 0, 0, 0};

    vecs[0] = '{4'd5,  4'd7,  4'd6,  4'd9,  4'hA, 4'd0,  4'd2,  4'd1,  4'd4,  2'd0};
    vecs[1] = '{4'd6,  4'd4,  4'd4,  4'd5,  4'h3, 4'd2,  4'd0,  4'd0,  4'd1,  2'd1};
    vecs[2] = '{4'd3,  4'd3,  4'd3,  4'd3,  4'hF, 4'd0,  4'd0,  4'd0,  4'd0,  2'd0};
    vecs[3] = '{4'd9,  4'd8,  4'd7,  4'd6,  4'h5, 4'd3,  4'd2,  4'd1,  4'd0,  2'd3};
    vecs[4] = '{4'd7,  4'd9,  4'd5,  4'd5,  4'h0, 4'd2,  4'd4,  4'd0,  4'd0,  2'd2};
    vecs[5] = '{4'd15, 4'd0,  4'd15, 4'd0,  4'h6, 4'd15, 4'd0,  4'd15, 4'd0,  2'd1};
    vecs[6] = '{4'd0,  4'd15, 4'd15, 4'd15, 4'h9, 4'd0,  4'd15, 4'd15, 4'd15, 2'd0};

    repeat (3) tick();
    settle();
    chk_pm("reset");
    chk("reset_busy", busy, 0);
    chk("reset_ready", sym_ready, 0);
    chk("reset_we", surv_we, 0);
    chk("reset_addr", surv_addr, 0);
    chk("reset_data", surv_data, 0);
    chk("reset_tb_start", tb_start, 0);
    chk("reset_tb_state", tb_state, 0);
    chk("reset_tb_len", tb_len, 0);
    chk("reset_frame_done", frame_done, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single-symbol frames: renormalization and best-state tie-break.
    for (int k = 0; k < 7; k++) begin
      start = 1'b1; frame_len = 7'd1;
      tick();
      start = 1'b0;
      {acs00_cost, acs01_cost, acs10_cost, acs11_cost} =
        {vecs[k].c0, vecs[k].c1, vecs[k].c2, vecs[k].c3};
      acs_sel = vecs[k].sel; sym_valid = 1'b1;
      settle();
      chk("vec_we", surv_we, 1);
      chk("vec_addr", surv_addr, 0);
      chk("vec_data", surv_data, vecs[k].sel);
      tick();
      sym_valid = 1'b0;
      settle();
      chk("vec_pm", {pm00, pm01, pm10, pm11},
          {vecs[k].p0, vecs[k].p1, vecs[k].p2, vecs[k].p3});
      chk("vec_tb_start", tb_start, 1);
      chk("vec_tb_state", tb_state, vecs[k].best);
      chk("vec_tb_len", tb_len, 1);
      tick();
      tb_done = 1'b1;
      tick();
      tb_done = 1'b0;
      settle();
      chk("vec_frame_done", frame_done, 1);
      tick();
    end

    run_frame(3, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("fixed_end_pm", {pm00, pm01, pm10, pm11}, {4'd0, 4'd2, 4'd1, 4'd4});
    run_frame(3, 1'b1, 1'b1, 32'b11001, 1'b0);
    run_frame(64, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Reset in the middle of a frame.
    start = 1'b1; frame_len = 7'd5;
    tick();
    start = 1'b0;
    repeat (2) begin
      {acs00_cost, acs01_cost, acs10_cost, acs11_cost} = {4'd2, 4'd3, 4'd4, 4'd5};
      sym_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("abort_busy", busy, 0);
    chk("abort_pm", {pm00, pm01, pm10, pm11}, 16'h0);
    chk("abort_we", surv_we, 0);
    chk("abort_tb_start", tb_start, 0);
    tick();
    settle();
    chk("abort2_we", surv_we, 0);
    chk("abort2_tb_start", tb_start, 0);
    tick();
    sym_valid = 1'b0;
    exp_q.delete();
    run_frame(1, 1'b1, 1'b0, 32'h0, 1'b0);

    run_frame(6, 1'b1, 1'b0, 32'h0, 1'b1);

    // Zero-length start is ignored.
    start = 1'b1; frame_len = 7'd0;
    tick();
    start = 1'b0;
    settle();
    chk("zero_len_busy", busy, 0);
    chk("zero_len_ready", sym_ready, 0);
    tick();

    repeat (6) run_frame($urandom_range(1, 20), 1'b1, 1'b0, 32'h0, 1'($urandom_range(0, 1)));

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
